scaled_encoder: RTL and testbench
=================================

# scaled_encoder

Sequential encoder that converts a wide signed fixed-point value with 7 fractional bits into the 16-bit scaled word used by the ODE datapath. The scaled word is {scale[2:0], mant[12:0]}, with value = mant / 2^scale. The block is the packing side of the scaled-format arithmetic: adder/subtractor operands are decoded and aligned from this format, and this block re-encodes wide intermediate results into it. It picks the largest scale, which gives the most precision, whose mantissa fits in 13 signed bits. The search shifts one bit per cycle behind valid/ready handshakes.

## Interface
- IN_WIDTH, 24, width of signed input; value = in_data / 2^7; legal range 14..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input (high only in IDLE)
- in_data  in  IN_WIDTH  signed fixed-point input, 7 fractional bits
- out_valid  out  1  out_data/flags valid (high only in DONE)
- out_ready  in  1  consumer accepts output
- out_data  out  16  {scale[2:0], mant[12:0]}
- overflow  out  1  value did not fit at scale 0; mantissa saturated
- inexact  out  1  at least one nonzero bit was discarded by shifting
- busy  out  1  state != IDLE

## Operation
- States are IDLE, CHECK and DONE.
- **Reset:** state=IDLE, in_ready=1, out_valid=0, out_data=0, overflow=0, inexact=0, busy=0. Internal x, s and sticky are cleared.
- **IDLE:** when in_valid && in_ready, capture x <= in_data, s <= 7, sticky <= 0, then go to CHECK.
- **CHECK, fit test:** x fits when x[IN_WIDTH-1:12] is all-ones or all-zeros.
  - If it fits: out_data <= {s, x[12:0]}, overflow <= 0, inexact <= sticky, go to DONE.
  - Else if s != 0: x <= x >>> 1 (arithmetic shift, truncates toward -inf), sticky <= sticky | x[0], s <= s-1, stay in CHECK.
  - Else (s == 0, no fit): out_data <= {3'd0, x[IN_WIDTH-1] ? 13'h1000 : 13'h0FFF}, overflow <= 1, inexact <= 1, go to DONE.
- **DONE:** out_valid=1. out_data, overflow and inexact are held stable until out_valid && out_ready, then go to IDLE.
- **Flag validity:** overflow and inexact are meaningful only while out_valid=1. They hold their last values otherwise and are cleared only by reset.
- **No pipelining:** one transaction is in flight at a time. in_ready=0 in CHECK and DONE. in_data is ignored outside IDLE.
- **Zero input:** fits immediately and gives out_data=16'hE000.
- **Minimum input:** the most negative input (-2^(IN_WIDTH-1)) saturates to 13'h1000 when it still does not fit at s=0.

## Timing
- **Latency:** with k shifts (0..7), out_valid rises k+1 cycles after the accepting edge. Minimum 1 cycle, maximum 8 (including the overflow case).
- **Throughput:** the earliest next accept is the edge after the out handshake. in_ready rises in the cycle following out_valid && out_ready, so there is no same-cycle DONE→accept bypass.
- **Backpressure:** out_ready low in DONE holds all outputs indefinitely with no change.
- **Asynchronous reset:** rst asserted in any state forces the reset values immediately, without waiting for clk. Any in-flight transaction is dropped with no output.
- **Recovery:** the first accept is possible on the first clk edge after rst deasserts.
- **Early out_ready:** out_ready asserted before out_valid has no effect.

## Test plan
- **Exact, no shift:** in_data=24'h000100 (2.0) -> out_data=16'hE100, overflow=0, inexact=0, out_valid 1 cycle after accept.
- **Exact, five shifts:** in_data=24'h010000 (512.0) -> 5 shifts, out_data=16'h4800, inexact=0, latency 6 cycles.
- **Negative, plus inexact:**
  - in_data=24'hFFFF00 (-2.0) -> 16'hFF00, latency 1.
  - in_data=24'h001001 -> 16'hC800, inexact=1, latency 2.
- **Overflow saturation, both signs, latency 8:**
  - in_data=24'h7FFFFF -> 16'h0FFF, overflow=1, inexact=1.
  - in_data=24'h800000 -> 16'h1000, overflow=1.
- **Handshake:**
  - Hold out_ready=0 for 10 cycles in DONE -> out_data and flags stable, in_ready=0.
  - Pulse out_ready -> IDLE.
  - Back-to-back inputs accepted only after each handshake, in order.
- **Reset mid-operation:** assert rst during CHECK of 24'h7FFFFF -> outputs reset asynchronously, no out_valid.
  - After deassert, 24'h000100 -> 16'hE100 with correct latency.

Source files
------------

// File: rtl/scaled_encoder_if.sv
// Handshake bundle for the scaled-format encoder: one input stream carrying
// wide signed fixed-point values and one output stream carrying the packed
// {scale, mantissa} word with its flags.
interface scaled_encoder_if #(
  parameter int IN_WIDTH = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [15:0]         out_data;
  logic                overflow;
  logic                inexact;

  // Encoder side: consumes in_*, produces out_* and flags.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, overflow, inexact
  );

  // Producer/consumer side around the encoder.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, overflow, inexact
  );
endinterface

// File: rtl/scaled_encoder.sv
// Packs a wide signed fixed-point value (7 fractional bits) into the 16-bit
// scaled word {scale[2:0], mant[12:0]} where value = mant / 2^scale.
// Starting at scale 7, the value is shifted right one bit per cycle until the
// mantissa fits in 13 signed bits; if it still does not fit at scale 0 the
// mantissa saturates. One transaction is in flight at a time.
module scaled_encoder #(
  parameter int IN_WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  scaled_encoder_if.slave   bus,
  output logic              busy
);

  localparam int MANT_W  = 13;
  localparam int FIT_LSB = MANT_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state;
  logic signed [IN_WIDTH-1:0] x;
  logic [2:0]                 s;
  logic                       sticky;
  logic                       in_ready;
  logic                       out_valid;
  logic [15:0]                out_data;
  logic                       overflow;
  logic                       inexact;
  logic                       fits;

  // The mantissa fits in 13 signed bits when every bit from the mantissa
  // sign position upward is a copy of the sign.
  assign fits = (&x[IN_WIDTH-1:FIT_LSB]) | ~(|x[IN_WIDTH-1:FIT_LSB]);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.overflow  = overflow;
  assign bus.inexact   = inexact;

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      s         <= 3'd0;
      sticky    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            x        <= bus.in_data;
            s        <= 3'd7;
            sticky   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end

        CHECK: begin
          if (fits) begin
            out_data  <= {s, x[MANT_W-1:0]};
            overflow  <= 1'b0;
            inexact   <= sticky;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (s != 3'd0) begin
            // Arithmetic shift floors toward -inf; remember any lost 1 bit.
            x      <= x >>> 1;
            sticky <= sticky | x[0];
            s      <= s - 3'd1;
          end else begin
            out_data  <= {3'd0, x[IN_WIDTH-1] ? 13'h1000 : 13'h0FFF};
            overflow  <= 1'b1;
            inexact   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Outputs hold until the consumer takes them; no bypass to accept.
          if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scaled_encoder.sv
// Directed and randomized checks of scaled_encoder against an arithmetic
// reference: choose the largest scale whose floored mantissa fits 13 bits.
module tb_scaled_encoder;

  localparam int W = 24;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  scaled_encoder_if #(.IN_WIDTH(W)) bus ();

  scaled_encoder #(.IN_WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = d/128; mantissa at scale sc is floor(d * 2^sc / 128).
  task automatic model(input logic [W-1:0] d, output logic [15:0] od,
                       output logic ov, output logic ix, output int lat);
    longint v;
    longint m;
    bit     found;
    v     = longint'($signed(d));
    found = 0;
    od = 16'h0; ov = 0; ix = 0; lat = 0;
    for (int sc = 7; sc >= 0; sc--) begin
      if (!found) begin
        m = v >>> (7 - sc);
        if (m >= -4096 && m <= 4095) begin
          found = 1;
          od    = {3'(sc), 13'(m)};
          ov    = 0;
          ix    = (v != (m <<< (7 - sc)));
          lat   = 7 - sc + 1;
        end
      end
    end
    if (!found) begin
      od  = {3'd0, (v < 0) ? 13'h1000 : 13'h0FFF};
      ov  = 1;
      ix  = 1;
      lat = 8;
    end
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] d,
                         input logic [15:0] e_od, input logic e_ov, input logic e_ix,
                         input int e_lat, input int stall, input bit early);
    int cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ".ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = early;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".in_ready_low"}, 32'(bus.in_ready), 32'd0);
    cnt = 0;
    while (!bus.out_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ".latency"}, 32'(cnt), 32'(e_lat));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(e_od));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(e_ov));
    chk({tag, ".inexact"}, 32'(bus.inexact), 32'(e_ix));
    chk({tag, ".in_ready_done"}, 32'(bus.in_ready), 32'd0);
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, ".stall_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".stall_data"}, {13'd0, bus.overflow, bus.inexact, 1'b0, bus.out_data},
            {13'd0, e_ov, e_ix, 1'b0, e_od});
        chk({tag, ".stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".valid_dropped"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0]       m_od;
    logic              m_ov;
    logic              m_ix;
    int                m_lat;
    logic signed [W-1:0] r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.out_data", 32'(bus.out_data), 32'd0);
    chk("reset.flags", {30'd0, bus.overflow, bus.inexact}, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Directed cases with hand-derived expectations
    run_txn("exact2",   24'h000100, 16'hE100, 0, 0, 1, 0, 0);
    run_txn("exact512", 24'h010000, 16'h4800, 0, 0, 6, 0, 0);
    run_txn("neg2",     24'hFFFF00, 16'hFF00, 0, 0, 1, 0, 0);
    run_txn("inexact",  24'h001001, 16'hC800, 0, 1, 2, 0, 0);
    run_txn("zero",     24'h000000, 16'hE000, 0, 0, 1, 0, 1);
    run_txn("satpos",   24'h7FFFFF, 16'h0FFF, 1, 1, 8, 0, 0);
    run_txn("hold10",   24'h000100, 16'hE100, 0, 0, 1, 10, 0);
    run_txn("satneg",   24'h800000, 16'h1000, 1, 1, 8, 3, 0);

    // Reset during CHECK of an overflowing value drops it
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h7FFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.out_data", 32'(bus.out_data), 32'd0);
    chk("midrst.flags", {30'd0, bus.overflow, bus.inexact}, 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst.no_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    run_txn("recover", 24'h000100, 16'hE100, 0, 0, 1, 0, 0);

    // Randomized back-to-back traffic against the reference
    for (int n = 0; n < 60; n++) begin
      r = W'($urandom);
      r = r >>> $urandom_range(0, W - 1);
      model(r, m_od, m_ov, m_ix, m_lat);
      run_txn($sformatf("rand%0d", n), r, m_od, m_ov, m_ix, m_lat,
              $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
